// File: rtl/button_event_scheduler.sv
// Debounced push-buttons -> round-robin arbitrated press/release event FIFO (valid/ready out).
// Event valid one clk after btn_state toggles; a full FIFO holds edges in pending bits until overwritten.
// BTN_AUTOREPEAT_EN adds periodic press events while a button stays held.
module button_event_scheduler #(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [2:0]         evt_id,
    output logic               evt_down,
    output logic               overflow,
    input  logic               clear_ovf
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(NUM_BTN);

    logic [PW-1:0]      pre_q;
    logic               tick;
    logic [NUM_BTN-1:0] s1_q, s2_q;
    logic [NUM_BTN-1:0] state_q, state_d;
    logic [7:0]         dcnt_q [NUM_BTN];
    logic [7:0]         dcnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] evt_set, evt_type, rep_set, set_v, typ_v;
    logic [NUM_BTN-1:0] pend_q, pend_d, ptype_q, ptype_d;
    logic               ovf_q, ovf_d, ovf_set;
    logic [IW-1:0]      rr_q, rr_d, grant_idx;
    logic               found, push, pop, full;
    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        fcnt_q, fcnt_d;
    int                 j;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        evt_set  = '0;
        evt_type = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            dcnt_d[i] = dcnt_q[i];
            if (tick) begin
                if (s2_q[i] == state_q[i]) begin
                    dcnt_d[i] = '0;
                end else if (dcnt_q[i] == 8'(STABLE_TICKS - 1)) begin
                    dcnt_d[i]   = '0;
                    state_d[i]  = ~state_q[i];
                    evt_set[i]  = 1'b1;
                    evt_type[i] = ~state_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 8'd1;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS);
    logic [RW-1:0] rep_q [NUM_BTN];
    logic [RW-1:0] rep_d [NUM_BTN];

    // A press toggle restarts the interval; the toggle itself is the first press event.
    always_comb begin
        rep_set = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_d[i] = rep_q[i];
            if (tick) begin
                if (state_q[i] && !evt_set[i]) begin
                    if (rep_q[i] == RW'(REPEAT_TICKS - 1)) begin
                        rep_d[i]   = '0;
                        rep_set[i] = 1'b1;
                    end else begin
                        rep_d[i] = rep_q[i] + RW'(1);
                    end
                end else begin
                    rep_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) rep_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) rep_q[i] <= rep_d[i];
        end
    end
`else
    assign rep_set = '0;
`endif

    assign set_v = evt_set | rep_set;
    assign typ_v = (evt_set & evt_type) | rep_set;

    assign full = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop  = evt_valid & evt_ready;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = 0; k < NUM_BTN; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_BTN) j = j - NUM_BTN;
            if (!found && pend_q[IW'(j)]) begin
                found     = 1'b1;
                grant_idx = IW'(j);
            end
        end
        push = found & (~full | pop);
        rr_d = rr_q;
        if (push) rr_d = (grant_idx == IW'(NUM_BTN - 1)) ? '0 : grant_idx + IW'(1);
    end

    // A new edge only loses data if an older one is still pending after this cycle's grant.
    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        ovf_set = 1'b0;
        if (push) pend_d[grant_idx] = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (set_v[i]) begin
                if (pend_d[i]) ovf_set = 1'b1;
                pend_d[i]  = 1'b1;
                ptype_d[i] = typ_v[i];
            end
        end
        ovf_d = ovf_set | (ovf_q & ~clear_ovf);
    end

    always_comb begin
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
            2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= '0;
            pend_q  <= '0;
            ptype_q <= '0;
            ovf_q   <= 1'b0;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
            for (int i = 0; i < NUM_BTN; i++) dcnt_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pre_q   <= tick ? '0 : pre_q + PW'(1);
            s1_q    <= ~btn_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            fcnt_q  <= fcnt_d;
            for (int i = 0; i < NUM_BTN; i++) dcnt_q[i] <= dcnt_d[i];
            if (push) begin
                mem_q[wr_q] <= {3'(grant_idx), ptype_q[grant_idx]};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
        end
    end

    assign btn_state = state_q;
    assign overflow  = ovf_q;
    assign evt_valid = (fcnt_q != '0);
    assign evt_id    = mem_q[rd_q][3:1];
    assign evt_down  = mem_q[rd_q][0];
endmodule
